// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: state encoding and parameter defaults shared by pipeline_ctrl
package pipe_ctrl_pkg;
    typedef enum logic [1:0] {RUN, MWAIT, ERR} state_t;
    localparam int DEF_TIMEOUT = 255;
    localparam int DEF_CW = 16;
endpackage

// File: rtl/sat_cnt.sv
// sat_cnt: up counter with synchronous clear that holds at all-ones
module sat_cnt #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);
    logic [W-1:0] r_cnt;
    // clear wins; increment only while below all-ones
    always_ff @(posedge i_clk) begin
        if (i_clr) r_cnt <= '0;
        else if (i_inc && !(&r_cnt)) r_cnt <= r_cnt + W'(1);
    end
    assign o_cnt = r_cnt;
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard, flush and memory-wait controller for a 5-stage pipeline
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int CW = DEF_CW
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [4:0]    id_rs,
    input  logic [4:0]    id_rt,
    input  logic          id_uses_rt,
    input  logic          ex_memread,
    input  logic [4:0]    ex_rt,
    input  logic          ex_branch_taken,
    input  logic          mem_req,
    input  logic          mem_ready,
    output logic          pc_we,
    output logic          ifid_we,
    output logic          idex_we,
    output logic          exmem_we,
    output logic          ifid_flush,
    output logic          idex_flush,
    output logic          memwb_bubble,
    output logic [CW-1:0] stall_cnt,
    output logic [CW-1:0] flush_cnt,
    output logic          err
);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] TO = WW'(TIMEOUT);
    state_t r_state, w_next;
    logic [WW-1:0] r_wait, w_wait_next;
    logic w_mem_wait, w_load_use, w_stall_inc, w_flush_inc;
    assign w_mem_wait = mem_req & ~mem_ready;
    assign w_load_use = ex_memread & (ex_rt != 5'd0) &
                        ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
    // reset overrides everything; a memory wait freezes the pipe and hides branch/load-use,
    // which EX and ID re-present once memory completes
    always_comb begin
        pc_we = 1'b1;
        ifid_we = 1'b1;
        idex_we = 1'b1;
        exmem_we = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        memwb_bubble = 1'b0;
        err = 1'b0;
        w_stall_inc = 1'b0;
        w_flush_inc = 1'b0;
        w_next = r_state;
        w_wait_next = r_wait;
        if (RST) begin
            {pc_we, ifid_we, idex_we, exmem_we} = 4'b0000;
            {ifid_flush, idex_flush, memwb_bubble} = 3'b111;
        end else if (r_state == ERR) begin
            {pc_we, ifid_we, idex_we, exmem_we} = 4'b0000;
            memwb_bubble = 1'b1;
            err = 1'b1;
        end else if (w_mem_wait) begin
            {pc_we, ifid_we, idex_we, exmem_we} = 4'b0000;
            memwb_bubble = 1'b1;
            w_stall_inc = 1'b1;
            w_wait_next = (r_state == RUN) ? WW'(1) : r_wait + WW'(1);
            w_next = (r_state == MWAIT && r_wait == TO) ? ERR : MWAIT;
        end else begin
            w_next = RUN;
            w_wait_next = '0;
            if (ex_branch_taken) begin
                {ifid_flush, idex_flush} = 2'b11;
                w_flush_inc = 1'b1;
            end else if (w_load_use) begin
                {pc_we, ifid_we} = 2'b00;
                idex_flush = 1'b1;
                w_stall_inc = 1'b1;
            end
        end
    end
    // state and consecutive-wait count
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= RUN;
            r_wait <= '0;
        end else begin
            r_state <= w_next;
            r_wait <= w_wait_next;
        end
    end
    sat_cnt #(.W(CW)) u_stall (.i_clk(CLK), .i_clr(RST), .i_inc(w_stall_inc), .o_cnt(stall_cnt));
    sat_cnt #(.W(CW)) u_flush (.i_clk(CLK), .i_clr(RST), .i_inc(w_flush_inc), .o_cnt(flush_cnt));
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: randomized and directed checks of pipeline_ctrl against a rule-level model
module tb_pipeline_ctrl;
    localparam int TO = 4;
    logic CLK = 1'b0, RST = 1'b1;
    logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
    logic id_uses_rt = 1'b0, ex_memread = 1'b0, ex_branch_taken = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;
    logic pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_flush, memwb_bubble, err;
    logic [15:0] stall_cnt, flush_cnt;
    logic s_pc_we, s_ifid_we, s_idex_we, s_exmem_we, s_ifid_flush, s_idex_flush, s_memwb_bubble, s_err;
    logic [1:0] s_stall_cnt, s_flush_cnt;
    int checks = 0, errors = 0;
    int m_stall = 0, m_flush = 0, m_waits = 0;
    bit m_err = 0;

    pipeline_ctrl #(.TIMEOUT(TO), .CW(16)) dut (
        .CLK(CLK), .RST(RST), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_memread(ex_memread), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready), .pc_we(pc_we), .ifid_we(ifid_we),
        .idex_we(idex_we), .exmem_we(exmem_we), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .memwb_bubble(memwb_bubble), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .err(err));

    pipeline_ctrl #(.TIMEOUT(TO), .CW(2)) dut_s (
        .CLK(CLK), .RST(RST), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_memread(ex_memread), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready), .pc_we(s_pc_we), .ifid_we(s_ifid_we),
        .idex_we(s_idex_we), .exmem_we(s_exmem_we), .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush),
        .memwb_bubble(s_memwb_bubble), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt), .err(s_err));

    always #5 CLK = ~CLK;

    wire [51:0] w_obs = {pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_flush, memwb_bubble, err,
                         stall_cnt, flush_cnt,
                         s_pc_we, s_ifid_we, s_idex_we, s_exmem_we, s_ifid_flush, s_idex_flush,
                         s_memwb_bubble, s_err, s_stall_cnt, s_flush_cnt};

    function automatic logic [20:0] v(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                                      input logic u, input logic m, input logic [4:0] e,
                                      input logic b, input logic q, input logic y);
        return {r, rs, rt, u, m, e, b, q, y};
    endfunction

    function automatic bit mw();
        return mem_req && !mem_ready;
    endfunction

    function automatic bit lu();
        return ex_memread && ex_rt != 0 && (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
    endfunction

    // expected outputs of both instances from the current inputs and the model
    function automatic logic [51:0] exp_v();
        logic [6:0] c;
        logic e;
        e = 1'b0;
        if (RST) c = 7'b0000111;
        else if (m_err) begin c = 7'b0000001; e = 1'b1; end
        else if (mw()) c = 7'b0000001;
        else if (ex_branch_taken) c = 7'b1111110;
        else if (lu()) c = 7'b0011010;
        else c = 7'b1111000;
        return {c, e, 16'(m_stall > 65535 ? 65535 : m_stall), 16'(m_flush > 65535 ? 65535 : m_flush),
                c, e, 2'(m_stall > 3 ? 3 : m_stall), 2'(m_flush > 3 ? 3 : m_flush)};
    endfunction

    task automatic drive(input logic [20:0] s);
        {RST, id_rs, id_rt, id_uses_rt, ex_memread, ex_rt, ex_branch_taken, mem_req, mem_ready} = s;
    endtask

    // advance one clock and apply the rules to the model
    task automatic tick();
        @(posedge CLK);
        if (RST) begin
            m_stall = 0; m_flush = 0; m_waits = 0; m_err = 0;
        end else if (!m_err) begin
            if (mw()) begin
                m_stall++;
                m_waits++;
                if (m_waits > TO) m_err = 1;
            end else begin
                m_waits = 0;
                if (ex_branch_taken) m_flush++;
                else if (lu()) m_stall++;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        logic [51:0] e;
        drive(v(1, 0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(v(1, 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), 5'($urandom),
                    1'($urandom), 1'($urandom), 1'($urandom)));
            @(negedge CLK);
            e = exp_v();
            checks++;
            if (w_obs !== e) begin errors++; $display("FAIL reset[%0d] got %h exp %h", i, w_obs, e); end
            tick();
        end
    endtask

    task automatic test_load_use();
        logic [20:0] s[$];
        logic [51:0] e;
        s = '{v(0, 0, 0, 0, 0, 0, 0, 0, 0), v(0, 5, 0, 0, 1, 5, 0, 0, 0), v(0, 0, 0, 0, 0, 0, 0, 0, 0),
              v(0, 0, 0, 0, 1, 0, 0, 0, 0), v(0, 3, 7, 1, 1, 7, 0, 0, 0), v(0, 3, 7, 0, 1, 7, 0, 0, 0),
              v(0, 5, 0, 0, 0, 5, 0, 0, 0), v(0, 0, 0, 0, 0, 0, 0, 0, 0)};
        foreach (s[i]) begin
            drive(s[i]);
            @(negedge CLK);
            e = exp_v();
            checks++;
            if (w_obs !== e) begin errors++; $display("FAIL load_use[%0d] got %h exp %h", i, w_obs, e); end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [20:0] s[$];
        logic [51:0] e;
        s = '{v(1, 0, 0, 0, 0, 0, 0, 0, 0), v(0, 5, 0, 0, 1, 5, 1, 0, 0), v(0, 0, 0, 0, 0, 0, 0, 0, 0),
              v(0, 2, 0, 0, 1, 2, 0, 0, 0), v(0, 0, 0, 0, 0, 0, 1, 1, 1), v(0, 4, 4, 1, 1, 4, 0, 1, 1),
              v(0, 0, 0, 0, 0, 0, 0, 0, 0)};
        foreach (s[i]) begin
            drive(s[i]);
            @(negedge CLK);
            e = exp_v();
            checks++;
            if (w_obs !== e) begin errors++; $display("FAIL back_to_back[%0d] got %h exp %h", i, w_obs, e); end
            tick();
        end
    endtask

    task automatic test_mem_wait();
        logic [20:0] s[$];
        logic [51:0] e;
        s = '{v(1, 0, 0, 0, 0, 0, 0, 0, 0), v(0, 0, 0, 0, 0, 0, 0, 1, 0), v(0, 5, 0, 0, 1, 5, 1, 1, 0),
              v(0, 6, 0, 0, 1, 6, 0, 1, 0), v(0, 0, 0, 0, 0, 0, 1, 1, 1), v(0, 0, 0, 0, 0, 0, 0, 0, 0),
              v(0, 0, 0, 0, 0, 0, 0, 1, 0), v(0, 3, 0, 0, 1, 3, 0, 0, 1), v(0, 0, 0, 0, 0, 0, 0, 0, 0)};
        foreach (s[i]) begin
            drive(s[i]);
            @(negedge CLK);
            e = exp_v();
            checks++;
            if (w_obs !== e) begin errors++; $display("FAIL mem_wait[%0d] got %h exp %h", i, w_obs, e); end
            tick();
        end
    endtask

    task automatic test_timeout();
        logic [20:0] s[$];
        logic [51:0] e;
        s = '{v(1, 0, 0, 0, 0, 0, 0, 0, 0)};
        for (int i = 0; i < 7; i++) s.push_back(v(0, 1, 0, 0, 1, 1, 1'(i), 1, 0));
        for (int i = 0; i < 3; i++) s.push_back(v(0, 0, 0, 0, 0, 0, 1, 1, 1));
        s.push_back(v(1, 0, 0, 0, 0, 0, 0, 1, 0));
        s.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0));
        s.push_back(v(0, 0, 0, 0, 0, 0, 1, 0, 0));
        foreach (s[i]) begin
            drive(s[i]);
            @(negedge CLK);
            e = exp_v();
            checks++;
            if (w_obs !== e) begin errors++; $display("FAIL timeout[%0d] got %h exp %h", i, w_obs, e); end
            tick();
        end
    endtask

    task automatic test_reset_mwait();
        logic [20:0] s[$];
        logic [51:0] e;
        s = '{v(1, 0, 0, 0, 0, 0, 0, 0, 0), v(0, 0, 0, 0, 0, 0, 1, 0, 0), v(0, 0, 0, 0, 0, 0, 0, 1, 0),
              v(0, 0, 0, 0, 0, 0, 0, 1, 0), v(1, 0, 0, 0, 0, 0, 0, 1, 0), v(0, 0, 0, 0, 0, 0, 0, 0, 0),
              v(0, 0, 0, 0, 0, 0, 0, 1, 0), v(0, 0, 0, 0, 0, 0, 0, 1, 1)};
        foreach (s[i]) begin
            drive(s[i]);
            @(negedge CLK);
            e = exp_v();
            checks++;
            if (w_obs !== e) begin errors++; $display("FAIL reset_mwait[%0d] got %h exp %h", i, w_obs, e); end
            tick();
        end
    endtask

    task automatic test_saturation();
        logic [20:0] s[$];
        logic [51:0] e;
        s = '{v(1, 0, 0, 0, 0, 0, 0, 0, 0)};
        for (int i = 0; i < 5; i++) s.push_back(v(0, 9, 0, 0, 1, 9, 0, 0, 0));
        for (int i = 0; i < 5; i++) s.push_back(v(0, 0, 0, 0, 0, 0, 1, 0, 0));
        s.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 0));
        s.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0));
        foreach (s[i]) begin
            drive(s[i]);
            @(negedge CLK);
            e = exp_v();
            checks++;
            if (w_obs !== e) begin errors++; $display("FAIL saturation[%0d] got %h exp %h", i, w_obs, e); end
            tick();
        end
    endtask

    task automatic test_random();
        logic [51:0] e;
        for (int i = 0; i < 600; i++) begin
            drive(v($urandom_range(0, 39) == 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)), $urandom_range(0, 3) == 0,
                    1'($urandom), $urandom_range(0, 3) == 0));
            @(negedge CLK);
            e = exp_v();
            checks++;
            if (w_obs !== e) begin errors++; $display("FAIL random[%0d] got %h exp %h", i, w_obs, e); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_back_to_back();
        test_mem_wait();
        test_timeout();
        test_reset_mwait();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: maximum consecutive memory-wait cycles before error.
REQ-002 SHALL have parameter CW, default 16: width of the performance counters.
REQ-003 SHALL have ports:
- CLK  in  1  the single clock; all state changes on posedge CLK.
- RST  in  1  synchronous, active-high reset.
- id_rs  in  5  ID-stage rs register number.
- id_rt  in  5  ID-stage rt register number.
- id_uses_rt  in  1  ID instruction reads rt.
- ex_memread  in  1  EX instruction is a load.
- ex_rt  in  5  EX load destination.
- ex_branch_taken  in  1  EX branch/jump resolved taken.
- mem_req  in  1  MEM stage accessing memory.
- mem_ready  in  1  memory completes this cycle.
- pc_we  out  1  PC load enable.
- ifid_we  out  1  IF/ID pipeline register enable.
- idex_we  out  1  ID/EX pipeline register enable.
- exmem_we  out  1  EX/MEM pipeline register enable.
- ifid_flush  out  1  load NOP into IF/ID.
- idex_flush  out  1  load NOP into ID/EX.
- memwb_bubble  out  1  load NOP into MEM/WB.
- stall_cnt  out  CW  saturating count of stall cycles.
- flush_cnt  out  CW  saturating count of branch flushes.
- err  out  1  sticky memory-timeout flag.

Function
REQ-004 Control outputs SHALL be combinational from the current state and inputs, so a hazard acts in the same cycle; counters, wait count and state SHALL be registered.
REQ-005 SHALL implement states RUN, MWAIT and ERR.
REQ-006 Condition precedence in RUN and MWAIT SHALL be: mem_wait, then branch, then load_use.
- mem_wait = mem_req & ~mem_ready.
- load_use = ex_memread & ex_rt!=0 & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)).
REQ-007 On mem_wait, the block SHALL drive pc_we, ifid_we, idex_we and exmem_we to 0, memwb_bubble=1, and both flushes to 0; a concurrent branch or load_use SHALL be ignored that cycle because EX and ID are frozen and re-present it.
REQ-008 On branch without mem_wait, the block SHALL drive all we to 1, ifid_flush=1 and idex_flush=1, and flush_cnt SHALL increment.
REQ-009 On load_use without mem_wait or branch, the block SHALL drive pc_we=0, ifid_we=0, idex_flush=1 and all other we to 1, and stall_cnt SHALL increment.
REQ-010 With no condition active, the block SHALL drive all we to 1 and all flush and bubble outputs to 0.
REQ-011 stall_cnt SHALL also increment on every mem_wait cycle; both counters SHALL saturate at 2^CW-1.
REQ-012 RUN -> MWAIT SHALL occur on mem_wait, with wait_cnt set to 1.
REQ-013 MWAIT SHALL hold while mem_wait and increment wait_cnt each such cycle.
REQ-014 MWAIT -> RUN SHALL occur in the cycle mem_ready=1, and outputs in that cycle SHALL follow REQ-008..010.
REQ-015 In MWAIT, when wait_cnt==TIMEOUT and mem_wait is still high, the next state SHALL be ERR.
REQ-016 In ERR, the block SHALL drive all we to 0, memwb_bubble=1 and err=1, ignoring all inputs until RST.
REQ-017 mem_req=1 with mem_ready=1 in the same cycle SHALL cause no stall.

Reset
REQ-018 While RST=1, the block SHALL drive pc_we, ifid_we, idex_we and exmem_we to 0, ifid_flush, idex_flush and memwb_bubble to 1, and err to 0.
REQ-019 On the posedge with RST=1, state SHALL become RUN and wait_cnt, stall_cnt, flush_cnt and err SHALL become 0.
REQ-020 RST asserted mid-MWAIT or in ERR SHALL behave identically to REQ-018..019.

Structure
REQ-021 Package pipe_ctrl_pkg SHALL hold the state encoding typedef (RUN, MWAIT, ERR) and the defaults for TIMEOUT and CW.
REQ-022 Sub-module sat_cnt (parameterised width, synchronous clear, increment enable, saturates at all-ones) SHALL be instantiated for stall_cnt and flush_cnt.

Verification
REQ-023 Load-use: ex_memread=1, ex_rt=5, id_rs=5 for 1 cycle -> pc_we=0, ifid_we=0, idex_flush=1 and stall_cnt 0->1; with ex_rt=0 there is no stall.
REQ-024 Branch plus load-use together -> ifid_flush=1, idex_flush=1, pc_we=1, flush_cnt=1 and stall_cnt=0.
REQ-025 mem_req=1 and mem_ready=0 for 3 cycles, then ready -> 3 frozen cycles with memwb_bubble=1, stall_cnt=3 and state back to RUN.
REQ-026 TIMEOUT=4, mem_ready held 0 -> err=1 after 5 wait cycles; err stays 1 after mem_ready=1 and clears only after RST.
REQ-027 Preload stall_cnt to 2^CW-2 and apply 3 stalls -> stall_cnt holds at 2^CW-1.
REQ-028 Assert RST in the 2nd cycle of MWAIT -> outputs at reset values, and on RST release state=RUN with counters at 0.
